// File: rtl/inbuf.sv
`default_nettype none
// ============================================================================
// Module   : inbuf
// Purpose  : Per-port input flit buffer. Stores incoming flits in a small
//            FIFO, checks HEAD/DATA/TAIL framing, returns one credit per
//            freed slot and presents the oldest flit to the output mux with
//            a valid/ready handshake.
// Ports    : clk, rst_ (sync, active-low)
//            idata/ivalid/ivch  - incoming flit, valid, VC tag
//            odata/ovalid/ovch  - head flit, valid, VC of current packet
//            oreq               - head flit is a HEAD (allocation request)
//            iready             - consumer accepts odata this cycle
//            ocredit            - one-cycle pulse per freed slot
//            ocount             - registered occupancy
//            oerr_ovf/oerr_proto- sticky overflow / framing errors
// Config   : define INBUF_BYPASS_EN to let a legal flit arriving at an empty
//            buffer with iready=1 cut straight through to the output.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif

module inbuf #(
    parameter int DATA_W = 67,
    parameter int TYPE_W = 3,
    parameter int VCH_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [DATA_W-1:0]          idata,
    input  logic                       ivalid,
    input  logic [VCH_W-1:0]           ivch,
    output logic                       ocredit,
    output logic [DATA_W-1:0]          odata,
    output logic                       ovalid,
    output logic [VCH_W-1:0]           ovch,
    output logic                       oreq,
    input  logic                       iready,
    output logic [$clog2(DEPTH+1)-1:0] ocount,
    output logic                       oerr_ovf,
    output logic                       oerr_proto
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + VCH_W;

    localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(DEPTH);
    localparam logic [TYPE_W-1:0] C_T_HEAD = TYPE_W'(`TYPE_HEAD);
    localparam logic [TYPE_W-1:0] C_T_DATA = TYPE_W'(`TYPE_DATA);
    localparam logic [TYPE_W-1:0] C_T_TAIL = TYPE_W'(`TYPE_TAIL);

    typedef enum logic [0:0] {I_IDLE = 1'b0, I_BODY = 1'b1} istate_t;
    typedef enum logic [0:0] {O_IDLE = 1'b0, O_PKT  = 1'b1} ostate_t;

    // Each entry keeps the flit together with the VC it arrived on.
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    istate_t           r_istate;
    istate_t           w_istate_nxt;
    ostate_t           r_ostate;
    ostate_t           w_ostate_nxt;
    logic [VCH_W-1:0]  r_ovch;
    logic [VCH_W-1:0]  w_ovch_nxt;
    logic              r_credit;
    logic              r_err_ovf;
    logic              r_err_proto;

    logic [TYPE_W-1:0] w_in_type;
    logic              w_legal;
    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_pop;
    logic              w_fifo_pop;
    logic              w_push;
    logic [ENT_W-1:0]  w_head_ent;
    logic [VCH_W-1:0]  w_head_vch;
    logic [TYPE_W-1:0] w_head_type;

    assign w_in_type = idata[DATA_W-1 -: TYPE_W];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);

    // A flit is legal only if it fits the framing state; anything else
    // (including NONE) is dropped before it can touch the FIFO.
    assign w_legal = ivalid &&
                     (((r_istate == I_IDLE) && (w_in_type == C_T_HEAD)) ||
                      ((r_istate == I_BODY) && ((w_in_type == C_T_DATA) ||
                                                (w_in_type == C_T_TAIL))));

`ifdef INBUF_BYPASS_EN
    assign w_bypass = w_empty && w_legal && iready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head_ent  = r_mem[r_rptr];
    assign ovalid      = w_bypass || !w_empty;
    assign odata       = w_bypass ? idata :
                         (w_empty ? '0 : w_head_ent[ENT_W-1 -: DATA_W]);
    assign w_head_vch  = w_bypass ? ivch : w_head_ent[VCH_W-1:0];
    assign w_head_type = odata[DATA_W-1 -: TYPE_W];

    // A bypassed flit counts as a pop (credit, output FSM) but never
    // occupies a slot, so it must not move the pointers or the count.
    assign w_pop      = ovalid && iready;
    assign w_fifo_pop = w_pop && !w_bypass;
    assign w_push     = w_legal && (!w_full || w_pop) && !w_bypass;

    assign oreq       = ovalid && (w_head_type == C_T_HEAD) && (r_ostate == O_IDLE);
    assign ovch       = r_ovch;
    assign ocredit    = r_credit;
    assign ocount     = r_count;
    assign oerr_ovf   = r_err_ovf;
    assign oerr_proto = r_err_proto;

    // Input framing: advances only on flits actually accepted.
    always_comb begin
        w_istate_nxt = r_istate;
        if (w_push || w_bypass) begin
            if (w_in_type == C_T_HEAD) begin
                w_istate_nxt = I_BODY;
            end else if (w_in_type == C_T_TAIL) begin
                w_istate_nxt = I_IDLE;
            end
        end
    end

    // Output packet tracking: VC is captured from the HEAD as it leaves
    // and held until the next HEAD leaves.
    always_comb begin
        w_ostate_nxt = r_ostate;
        w_ovch_nxt   = r_ovch;
        if (w_pop) begin
            if (w_head_type == C_T_HEAD) begin
                w_ostate_nxt = O_PKT;
                w_ovch_nxt   = w_head_vch;
            end else if (w_head_type == C_T_TAIL) begin
                w_ostate_nxt = O_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_istate    <= I_IDLE;
            r_ostate    <= O_IDLE;
            r_ovch      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_credit    <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_istate <= w_istate_nxt;
            r_ostate <= w_ostate_nxt;
            r_ovch   <= w_ovch_nxt;
            r_credit <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_fifo_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_fifo_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_fifo_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_legal && w_full && !w_pop) begin
                r_err_ovf <= 1'b1;
            end
            if (ivalid && !w_legal) begin
                r_err_proto <= 1'b1;
            end
        end
    end

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_ && w_push) begin
            r_mem[r_wptr] <= {idata, ivch};
        end
    end

endmodule

`default_nettype wire
